// File: rtl/serial_alu_periph_pkg.sv
// serial_alu_pkg: mode encodings, register map offsets and STATUS bit positions
package serial_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_AND = 2'b10,
        MODE_XOR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_OPA    = 3'd1;
    localparam logic [2:0] REG_OPB    = 3'd2;
    localparam logic [2:0] REG_RESULT = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_COUT = 2;
    localparam int ST_ZERO = 3;
    localparam int ST_OVF  = 4;
    localparam int ST_ERR  = 5;
    localparam int ST_IRQ  = 6;

    function automatic logic [31:0] wb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/serial_alu_periph_slice.sv
// alu_slice: combinational LANES-bit ALU slice with carry in/out; carry out is 0 in logic modes
module alu_slice
    import serial_alu_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic [LANES-1:0] i_a,
    input  logic [LANES-1:0] i_b,
    input  mode_e            i_mode,
    input  logic             i_cin,
    output logic [LANES-1:0] o_res,
    output logic             o_cout
);
    logic [LANES:0] w_sum;

    always_comb begin
        w_sum  = {1'b0, i_a} + {1'b0, (i_mode == MODE_SUB) ? ~i_b : i_b} + {{LANES{1'b0}}, i_cin};
        o_res  = (i_mode == MODE_AND) ? (i_a & i_b) :
                 (i_mode == MODE_XOR) ? (i_a ^ i_b) : w_sum[LANES-1:0];
        o_cout = (i_mode == MODE_ADD || i_mode == MODE_SUB) & w_sum[LANES];
    end

endmodule

// File: rtl/serial_alu_periph.sv
// serial_alu_periph: Wishbone-mapped ALU computing LANES bits per clock, LSB-first.
// Define ALU_IRQ_EN to add the sticky done interrupt (irq_pend / irq_o).
module serial_alu_periph
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        irq_o
);
    localparam int STEPS = WIDTH / LANES;
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 1 || WIDTH > 32 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_cfg
        $error("serial_alu_periph: WIDTH must be 1..32 and a multiple of LANES");
    end

    state_e           r_state, w_state_nxt;
    mode_e            r_mode;
    logic             r_cin, r_ack, r_carry, r_am, r_bm;
    logic             r_cout, r_zero, r_ovf, r_done, r_err;
    logic [31:0]      r_dat;
    logic [WIDTH-1:0] r_opa, r_opb, r_sa, r_sb, r_acc, r_result;
    logic [CW-1:0]    r_cnt;

    logic             w_req, w_wr, w_busy, w_start, w_go, w_op_wr, w_st_wr, w_err_set, w_last;
    logic             w_sc, w_ovf, w_irq;
    logic [2:0]       w_addr;
    mode_e            w_mode_in;
    logic [LANES-1:0] w_res;
    logic [WIDTH-1:0] w_res_ext, w_acc_nxt;
    logic [31:0]      w_status, w_rdata;
    logic             w_unused;

    assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_addr    = wbs_adr_i[4:2];
    assign w_busy    = r_state == S_RUN;
    assign w_start   = w_wr && w_addr == REG_CTRL && wbs_dat_i[0];
    assign w_go      = w_start && r_state == S_IDLE;
    assign w_op_wr   = w_wr && (w_addr == REG_OPA || w_addr == REG_OPB);
    assign w_st_wr   = w_wr && w_addr == REG_STATUS;
    assign w_err_set = (w_start && r_state != S_IDLE) || (w_op_wr && w_busy);
    assign w_last    = w_busy && r_cnt == CW'(1);
    assign w_mode_in = mode_e'(wbs_dat_i[2:1]);
    assign w_unused  = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    alu_slice #(.LANES(LANES)) u_slice (
        .i_a   (r_sa[LANES-1:0]),
        .i_b   (r_sb[LANES-1:0]),
        .i_mode(r_mode),
        .i_cin (r_carry),
        .o_res (w_res),
        .o_cout(w_sc)
    );

    // each new slice enters at the top so the first (LSB) slice ends at bit 0
    assign w_res_ext = WIDTH'(w_res);
    assign w_acc_nxt = (r_acc >> LANES) | (w_res_ext << (WIDTH - LANES));
    assign w_ovf     = (r_mode == MODE_ADD || r_mode == MODE_SUB) && r_am == r_bm &&
                       w_acc_nxt[WIDTH-1] != r_am;

    assign w_status = {25'd0, w_irq, r_err, r_ovf, r_zero, r_cout, r_done, w_busy};
    assign w_rdata  = (w_addr == REG_CTRL)   ? {28'd0, r_cin, r_mode, 1'b0} :
                      (w_addr == REG_OPA)    ? 32'(r_opa) :
                      (w_addr == REG_OPB)    ? 32'(r_opb) :
                      (w_addr == REG_RESULT) ? 32'(r_result) :
                      (w_addr == REG_STATUS) ? w_status : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_go ? S_RUN : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_mode   <= MODE_ADD;
            r_cin    <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_sa     <= '0;
            r_sb     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_am     <= 1'b0;
            r_bm     <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_req;
            r_dat   <= w_req ? w_rdata : 32'd0;
            if (w_wr && w_addr == REG_OPA && !w_busy)
                r_opa <= WIDTH'(wb_merge(32'(r_opa), wbs_dat_i, wbs_sel_i));
            if (w_wr && w_addr == REG_OPB && !w_busy)
                r_opb <= WIDTH'(wb_merge(32'(r_opb), wbs_dat_i, wbs_sel_i));
            if (w_wr && w_addr == REG_CTRL && r_state == S_IDLE) begin
                r_mode <= w_mode_in;
                r_cin  <= wbs_dat_i[3];
            end
            if (w_go) begin
                r_sa    <= r_opa;
                r_sb    <= r_opb;
                r_carry <= (w_mode_in == MODE_SUB) ? 1'b1 : wbs_dat_i[3];
                r_cnt   <= CW'(STEPS);
                r_am    <= r_opa[WIDTH-1];
                r_bm    <= r_opb[WIDTH-1] ^ (w_mode_in == MODE_SUB);
            end else if (w_busy) begin
                r_sa    <= r_sa >> LANES;
                r_sb    <= r_sb >> LANES;
                r_acc   <= w_acc_nxt;
                r_carry <= w_sc;
                r_cnt   <= r_cnt - CW'(1);
            end
            if (w_last) begin
                r_result <= w_acc_nxt;
                r_cout   <= w_sc;
                r_zero   <= w_acc_nxt == '0;
                r_ovf    <= w_ovf;
            end
            r_done <= w_last | (r_done & ~(w_st_wr & wbs_dat_i[ST_DONE]));
            r_err  <= w_err_set | (r_err & ~(w_st_wr & wbs_dat_i[ST_ERR]));
        end
    end

`ifdef ALU_IRQ_EN
    logic r_irq;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_irq <= 1'b0;
        else          r_irq <= w_last | (r_irq & ~(w_st_wr & wbs_dat_i[ST_IRQ]));
    end
    assign w_irq = r_irq;
`else
    assign w_irq = 1'b0;
`endif

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign busy_o    = w_busy;
    assign done_o    = r_state == S_DONE;
    assign irq_o     = w_irq;

endmodule
